midi_msg_parser: RTL
====================

# midi_msg_parser

Byte-level MIDI message parser between the `rs232` receiver and the `midi_player` synth. It consumes the receiver's one-cycle byte strobes and tracks MIDI status, including running status. Complete note-on/note-off messages become decoded events, which are buffered in a small FIFO and presented on a valid/ready interface. All other messages are consumed and discarded without disturbing parser state.

## Interface
- `FIFO_DEPTH`, 4: event FIFO entries; must be a power of two, ≥2.
- `CHANNEL`, 4'd0: MIDI channel accepted when channel filtering is compiled in.
- `clk` in 1: system clock.
- `reset_n` in 1: reset is synchronous and active-low, sampled on the rising edge of `clk`.
- `new_byte` in 8: received byte; valid only while `new_byte_ready` is high.
- `new_byte_ready` in 1: one-cycle strobe from `rs232`.
- `ev_valid` out 1: FIFO head holds an event.
- `ev_ready` in 1: consumer accepts the head event when `ev_valid && ev_ready`.
- `ev_note_on` out 1: 1 = note-on, 0 = note-off.
- `ev_channel` out 4: channel of the event.
- `ev_note` out 7: note number.
- `ev_velocity` out 7: velocity, passed through raw.
- `ev_count` out $clog2(FIFO_DEPTH)+1: FIFO occupancy.
- `overflow` out 1: sticky; set when an event is dropped.

## Operation
- **Byte classes:**
  - Data: bit7 = 0.
  - Channel status: 0x80–0xEF.
  - System common: 0xF0–0xF7.
  - Real-time: 0xF8–0xFF.
- **Real-time bytes** are ignored completely. State, running status and partial data are untouched, so they may arrive between the data bytes of a message.
- **System common bytes** clear running status and go to `NO_STATUS`. SysEx payload data bytes are therefore discarded.
- **Channel status bytes** load `run_status` and go to `DATA1`. Any partially received message is abandoned.
- **Data-byte length** is taken from the status high nibble:
  - 0x8, 0x9, 0xA, 0xB, 0xE: two data bytes.
  - 0xC, 0xD: one data byte.
- **States:**
  - `NO_STATUS`: data bytes are discarded.
  - `DATA1` → data byte: store it in `d1`. Go to `DATA2` if the message is two-byte; otherwise the message is complete, go back to `DATA1`.
  - `DATA2` → data byte: the message is complete, go back to `DATA1`. Running status is retained, so repeated data pairs form new messages.
- **Events on completion:**
  - Nibble 0x9 with velocity ≠ 0 → note-on event.
  - Nibble 0x8, or nibble 0x9 with velocity = 0 → note-off event. Velocity is carried as received.
  - Every other completed message produces no event.
- **FIFO write:** occurs on the same edge as the completing byte. The FIFO is circular, with wrap-around pointers of width log2(FIFO_DEPTH).
- **Full FIFO:**
  - A write with no simultaneous pop is dropped and sets `overflow`.
  - A simultaneous pop and write when full succeeds; `ev_count` is unchanged.
- **Pop** occurs on the edge where `ev_valid && ev_ready`. When the FIFO is empty, `ev_ready` is a don't-care and the output fields hold stale data.
- **`overflow`** clears only on reset.

## Timing
- **On reset** (`reset_n` = 0 at an edge), all of the following hold from the next cycle:
  - state = `NO_STATUS`, `run_status` cleared.
  - FIFO empty, `ev_valid` = 0, `ev_count` = 0.
  - `overflow` = 0, and all `ev_*` fields = 0.
- **Reset mid-message** discards partial data and all queued events.
- **Latency:** the completing strobe at edge N gives `ev_valid` = 1 and the head fields valid from N+1 (FIFO previously empty).
- **Head fields** are driven from FIFO storage at the read pointer. They are stable while `ev_valid && !ev_ready`.
- **`ev_count`** updates on the edge after a push or pop; it is unchanged by a simultaneous push and pop.
- **Byte rate:** one byte is accepted per strobe. Back-to-back strobes on consecutive cycles must be handled.

## Configuration
- **`MIDI_CHANNEL_FILTER_EN`:**
  - Defined: only events whose channel equals `CHANNEL` are written.
  - Filtered messages are still parsed and still update running status and state; they produce no event and cannot set `overflow`.
  - Not defined: omni mode, where events from all 16 channels are written.

## Test plan
- **Basic note-on / note-off:** bytes 0x90, 0x3C, 0x64, then 0x80, 0x3C, 0x00 with `ev_ready` = 1.
  - First event: note-on, ch0, note 0x3C, velocity 0x64; `ev_valid` rises one cycle after the 0x64 strobe.
  - Second event: note-off, ch0, note 0x3C, velocity 0x00.
- **Running status and real-time interleave:** bytes 0x93, 0x40, 0x7F, 0x41, 0xF8, 0x00.
  - Two events: on ch3 0x40/0x7F, then off ch3 0x41/0x00 (the 0xF8 is ignored).
- **Discarded messages:** bytes 0xC0, 0x05, 0xB0, 0x07, 0x64, 0xF0, 0x12, 0x34, 0xF7, 0x3C, 0x40.
  - Zero events and `ev_valid` stays 0.
- **Overflow and simultaneous push/pop:** with `ev_ready` = 0, send 5 note-ons (FIFO_DEPTH = 4).
  - `ev_count` = 4 and `overflow` = 1; the head is the first note.
  - Then hold `ev_ready` = 1 while sending a sixth note-on: its write coincides with a pop and is accepted, and `ev_count` stays 4.
- **Reset mid-operation:** send 0x90, 0x3C, then `reset_n` = 0 for one cycle, then 0x40.
  - No event is produced.
  - After reset, `ev_count` = 0 and `overflow` = 0.
- **Channel filter** (with `MIDI_CHANNEL_FILTER_EN` defined, `CHANNEL` = 2): send note-ons on ch1 and ch2.
  - Only the ch2 event appears.

Source files
------------

// File: rtl/midi_msg_parser.sv
// MIDI byte parser: running status, note-on/off decode, event FIFO.
// Define MIDI_CHANNEL_FILTER_EN to accept only events on CHANNEL.
module midi_msg_parser #(
  parameter int         FIFO_DEPTH = 4,
  parameter logic [3:0] CHANNEL    = 4'd0
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [7:0]                  new_byte,
  input  logic                        new_byte_ready,
  output logic                        ev_valid,
  input  logic                        ev_ready,
  output logic                        ev_note_on,
  output logic [3:0]                  ev_channel,
  output logic [6:0]                  ev_note,
  output logic [6:0]                  ev_velocity,
  output logic [$clog2(FIFO_DEPTH):0] ev_count,
  output logic                        overflow
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [PW:0] FULL_CNT = FIFO_DEPTH[PW:0];

`ifdef MIDI_CHANNEL_FILTER_EN
  localparam logic FILTER_EN = 1'b1;
`else
  localparam logic FILTER_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    NO_STATUS,
    DATA1,
    DATA2
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic [7:0]  run_status;
  logic [7:0]  run_status_nx;
  logic [6:0]  d1;
  logic [6:0]  d1_nx;

  logic        is_data;
  logic        is_sys;
  logic        is_chan;
  logic        two_byte;
  logic        msg_done;
  logic        ev_hit;
  logic        ev_on;
  logic [18:0] wr_data;

  logic [18:0] mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic        full;
  logic        pop;
  logic        wr_req;
  logic        push;
  logic        drop;

  always_comb begin
    state_nx      = state;
    run_status_nx = run_status;
    d1_nx         = d1;
    msg_done      = 1'b0;
    is_data  = new_byte_ready && !new_byte[7];
    is_sys   = new_byte_ready && (new_byte[7:3] == 5'b11110);
    is_chan  = new_byte_ready && new_byte[7] &&
               (new_byte[7:4] != 4'hF);
    two_byte = !((run_status[7:4] == 4'hC) ||
                 (run_status[7:4] == 4'hD));
    // Real-time bytes fall through every branch untouched
    if (is_sys) begin
      state_nx      = NO_STATUS;
      run_status_nx = 8'h00;
    end else if (is_chan) begin
      state_nx      = DATA1;
      run_status_nx = new_byte;
    end else if (is_data) begin
      unique case (state)
        DATA1: begin
          d1_nx    = new_byte[6:0];
          state_nx = two_byte ? DATA2 : DATA1;
        end
        DATA2: begin
          state_nx = DATA1;
          msg_done = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    ev_hit  = msg_done &&
              ((run_status[7:4] == 4'h8) ||
               (run_status[7:4] == 4'h9));
    ev_on   = (run_status[7:4] == 4'h9) &&
              (new_byte[6:0] != 7'd0);
    wr_data = {ev_on, run_status[3:0],
               d1, new_byte[6:0]};
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= NO_STATUS;
      run_status <= 8'h00;
      d1         <= 7'd0;
    end else begin
      state      <= state_nx;
      run_status <= run_status_nx;
      d1         <= d1_nx;
    end
  end

  always_comb begin
    full     = (ev_count == FULL_CNT);
    ev_valid = (ev_count != '0);
    pop      = ev_valid && ev_ready;
    wr_req   = ev_hit &&
               (!FILTER_EN || (run_status[3:0] == CHANNEL));
    // A full FIFO still takes a write when the head leaves this edge
    push     = wr_req && (!full || pop);
    drop     = wr_req && full && !pop;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      ev_count <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push && !pop) begin
        ev_count <= ev_count + 1'b1;
      end else if (pop && !push) begin
        ev_count <= ev_count - 1'b1;
      end
      if (drop) begin
        overflow <= 1'b1;
      end
    end
  end

  assign {ev_note_on, ev_channel, ev_note, ev_velocity} =
    mem[rd_ptr];

endmodule
